// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM responder: FSM encoding, error
// data pattern and the default base address.
package sram_controller_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [31:0] ErrData         = 32'hDEAD_BEEF;
  localparam logic [31:0] DefaultBaseAddr = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times how long one halfword access is held on
// the SRAM pins. done is high while the count is zero.
module sram_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/sram_controller.sv
// Serves MEM-stage word reads/writes from a 16-bit SRAM as two halfword
// accesses. Define SRAM_ADDR_CHECK_EN to add the out-of-range check and addr_err.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned MEM_WORDS   = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n
`ifdef SRAM_ADDR_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  localparam int unsigned IW = SRAM_AW - 1;
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       offset;
  logic              req, addr_bad, accept;
  logic              cnt_load, cnt_dec, cnt_done;
  logic [SRAM_AW-1:0] sram_addr_d;
  logic [15:0]       dq_o_d;
  logic              dq_oe_d, we_n_d;

  assign req    = rd_en | wr_en;
  assign offset = address - BASE_ADDR;
  assign accept = (state_q == StIdle) && req;

`ifdef SRAM_ADDR_CHECK_EN
  assign addr_bad = (address < BASE_ADDR) || ((offset >> 2) >= 32'(MEM_WORDS));
`else
  assign addr_bad = 1'b0;
`endif

  // Bits outside the word index are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{offset[31:IW+2], offset[1:0], MEM_WORDS == 0};

  sram_wait_counter #(
    .WIDTH (4)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WaitLoad),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (addr_bad) begin
            state_d = StDone;
          end else begin
            state_d  = StLow;
            cnt_load = 1'b1;
          end
        end
      end
      StLow: begin
        if (cnt_done) begin
          state_d  = StHigh;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StHigh: begin
        if (cnt_done) begin
          state_d = StDone;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign op_wr_d = accept ? wr_en : op_wr_q;
  assign idx_d   = accept ? offset[IW+1:2] : idx_q;
  assign data_d  = accept ? write_data : data_q;

  // Pin values are registered from the next state so they line up with it.
  always_comb begin
    sram_addr_d = sram_addr;
    dq_o_d      = sram_dq_o;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    if ((state_d == StLow) || (state_d == StHigh)) begin
      sram_addr_d = {idx_d, state_d == StHigh};
      if (op_wr_d) begin
        dq_o_d  = (state_d == StHigh) ? data_d[31:16] : data_d[15:0];
        dq_oe_d = 1'b1;
        we_n_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_wr_q    <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      sram_addr  <= sram_addr_d;
      sram_dq_o  <= dq_o_d;
      sram_dq_oe <= dq_oe_d;
      sram_we_n  <= we_n_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (accept && addr_bad && !wr_en) begin
      read_data <= ErrData;
    end else if ((state_q == StLow) && cnt_done && !op_wr_q) begin
      read_data[15:0] <= sram_dq_i;
    end else if ((state_q == StHigh) && cnt_done && !op_wr_q) begin
      read_data[31:16] <= sram_dq_i;
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (accept && addr_bad) begin
      addr_err <= 1'b1;
    end
  end
`endif

  assign ready = ((state_q == StIdle) && !req) || (state_q == StDone);

endmodule

// File: tb/tb_sram_controller.sv
// Randomized self-checking bench for sram_controller against a word-level
// memory model and a cycle-position description of the SRAM pin protocol.
module tb_sram_controller;

  localparam int unsigned W = 4;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n;

  logic [15:0] sram_mem [1024];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rd;
  int          n_checks = 0;
  int          n_fail = 0;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i),
    .sram_we_n  (sram_we_n)
  );

  always #5 clk = ~clk;

  // Board SRAM: asynchronous read, write captured at the clock edge.
  assign sram_dq_i = sram_mem[sram_addr[9:0]];
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[9:0]] <= sram_dq_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issues one request and follows it until ready. b2b: the previous op has
  // just reached its ready cycle and this request follows with no gap.
  task automatic run_op(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit b2b, input bit scramble,
                        input int drop_rd_at);
    logic [16:0] idx;
    logic        hw;
    int          c;
    idx = 17'((addr - BASE) >> 2);
    if (!b2b) @(negedge clk);
    rd_en = do_rd;
    wr_en = do_wr;
    address = addr;
    write_data = data;
    if (b2b) @(negedge clk);
    c = 0;
    forever begin
      #1;
      if (ready) break;
      if (c >= 1) begin
        hw = (c > int'(W));
        check_eq("sram_addr", 32'(sram_addr), {14'b0, idx, hw});
        check_eq("we_n", 32'(sram_we_n), 32'(!do_wr));
        check_eq("dq_oe", 32'(sram_dq_oe), 32'(do_wr));
        if (do_wr) check_eq("dq_o", 32'(sram_dq_o), 32'(hw ? data[31:16] : data[15:0]));
      end
      if (c == drop_rd_at) rd_en = 1'b0;
      if (scramble && c >= 1) begin
        rd_en = 1'($urandom);
        wr_en = 1'($urandom);
        address = $urandom;
        write_data = $urandom;
      end
      c++;
      if (c > 4 * int'(W) + 10) break;
      @(negedge clk);
    end
    check_eq("stall_cycles", 32'(c), 32'(2 * W + 1));
    check_eq("done_we_n", 32'(sram_we_n), 32'd1);
    check_eq("done_oe", 32'(sram_dq_oe), 32'd0);
    if (do_wr) ref_mem[idx[7:0]] = data;
    else exp_rd = ref_mem[idx[7:0]];
    check_eq("read_data", read_data, exp_rd);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    bit          r, w, b2b;
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    write_data = '0;
    exp_rd = '0;
    for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = (i == 1) ? 32'hCAFE_BEEF : $urandom;
      sram_mem[2 * i] = ref_mem[i][15:0];
      sram_mem[2 * i + 1] = ref_mem[i][31:16];
    end

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_read_data", read_data, 32'd0);
    check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rst_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("rst_sram_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_dq_o", 32'(sram_dq_o), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 1'b1, 32'd1024, 32'h1234_5678, 1'b0, 1'b0, -1);
    run_op(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b0, -1);
    check_eq("cafebeef", read_data, 32'hCAFE_BEEF);
    run_op(1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, 1'b0, 1'b0, 2);
    check_eq("hw4", 32'(sram_mem[4]), 32'h0000_F00D);
    check_eq("hw5", 32'(sram_mem[5]), 32'h0000_0BAD);
    run_op(1'b0, 1'b1, 32'd1100, 32'h5A5A_C3C3, 1'b0, 1'b0, -1);
    run_op(1'b1, 1'b0, 32'd1100, 32'h0, 1'b1, 1'b0, -1);
    check_eq("b2b_read", read_data, 32'h5A5A_C3C3);
    // Index truncation: bit 19 of the offset falls outside the SRAM space.
    run_op(1'b0, 1'b1, BASE + 32'h0008_0000 + 32'd8, 32'h7777_1111, 1'b1, 1'b0, -1);
    run_op(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 1'b0, -1);

    // Reset during the second LOW cycle of a write.
    @(negedge clk);
    wr_en = 1'b1;
    address = 32'd1024;
    write_data = 32'hA5A5_0F0F;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wr_en = 1'b0;
    #1;
    check_eq("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("mid_rst_ready", 32'(ready), 32'd1);
    check_eq("mid_rst_read_data", read_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = '0;
    ref_mem[0] = {sram_mem[1], sram_mem[0]};

    for (int n = 0; n < 40; n++) begin
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      b2b = (n == 0) ? 1'b0 : 1'($urandom);
      d = $urandom;
      run_op(r, w, BASE + (($urandom % 4) << 19) + ($urandom_range(0, 255) << 2)
             + ($urandom % 4), d, b2b, 1'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
